c6502_bus: RTL

- Bus responder for the c6502 core: receives the CPU's address, write data and strobes, and returns read data plus the `ce` step enable.
- Each CPU step is one bus transaction. The block decodes the address into three regions (internal RAM, I/O window, external memory) and holds the CPU (`ce`=0) until the access completes.
- Sits between the core and the board memory/peripherals. It is the only source of the core's `ce`.

---
 rtl/c6502_bus_pkg.sv | 34 +++
 rtl/c6502_bus_if.sv | 37 +++
 rtl/c6502_bus_ram.sv | 21 ++
 rtl/c6502_bus.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/c6502_bus_pkg.sv
// Shared types and constants for the c6502 bus responder: FSM encoding,
// address region decode and the value returned on a timed-out access.
package c6502_bus_pkg;

  typedef enum logic [2:0] {
    S_ADDR = 3'd0,
    S_RAM  = 3'd1,
    S_IO   = 3'd2,
    S_EXT  = 3'd3,
    S_STEP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_IO  = 2'd1,
    REG_EXT = 2'd2
  } region_t;

  localparam logic [2:0] RAM_HI       = 3'b000;
  localparam logic [7:0] IO_BASE_DEF  = 8'h20;
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

  // RAM wins over the I/O window so that an IO_BASE inside $00-$1F stays harmless.
  function automatic region_t decode_region(input logic [15:0] addr,
                                            input logic [7:0]  io_base);
    if (addr[15:13] == RAM_HI)
      return REG_RAM;
    else if (addr[15:8] == io_base)
      return REG_IO;
    else
      return REG_EXT;
  endfunction

endpackage

// File: rtl/c6502_bus_if.sv
// Bus bundle between the c6502 core, the responder and the board side
// (I/O registers and external memory).
interface c6502_bus_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_rd;
  logic        cpu_we;
  logic [7:0]  cpu_in;
  logic        cpu_ce;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we;
  logic        io_rd;
  logic [7:0]  io_rdata;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic        bus_err;
  logic        bus_err_clr;

  modport slave (
    input  cpu_address, cpu_out, cpu_rd, cpu_we,
    input  io_rdata, ext_rdata, ext_ack, bus_err_clr,
    output cpu_in, cpu_ce, io_addr, io_wdata, io_we, io_rd,
    output ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );

  modport master (
    output cpu_address, cpu_out, cpu_rd, cpu_we,
    output io_rdata, ext_rdata, ext_ack, bus_err_clr,
    input  cpu_in, cpu_ce, io_addr, io_wdata, io_we, io_rd,
    input  ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );
endinterface

// File: rtl/c6502_bus_ram.sv
// Internal single-port RAM: synchronous write, registered read (one clock
// latency). Contents are not cleared by reset.
module c6502_ram #(
  parameter int AW = 11
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clock) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/c6502_bus.sv
// Bus responder for the c6502 core: decodes each CPU step into an internal
// RAM, I/O window or external access and releases the core with cpu_ce.
module c6502_bus
  import c6502_bus_pkg::*;
#(
  parameter int         RAM_AW  = 11,
  parameter logic [7:0] IO_BASE = IO_BASE_DEF,
  parameter int         TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  c6502_bus_if.slave  bus,
  output state_t      dbg_state
);

  // Step handshake: the core presents address/data/strobes and holds them
  // until it sees cpu_ce=1 for one clock; cpu_in is valid on that clock and
  // the core advances at its end. ext_req stays high until a one-clock
  // ext_ack (or the timeout) and is ignored by nobody else.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        we_q, we_n;
  logic [7:0]  wdata_q, wdata_n;
  logic [7:0]  cpu_in_q, cpu_in_n;
  logic        ce_q, ce_n;
  logic [7:0]  io_addr_q, io_addr_n;
  logic [7:0]  io_wdata_q, io_wdata_n;
  logic        io_we_q, io_we_n;
  logic        io_rd_q, io_rd_n;
  logic        ext_req_q, ext_req_n;
  logic        ext_we_q, ext_we_n;
  logic [15:0] ext_addr_q, ext_addr_n;
  logic [7:0]  ext_wdata_q, ext_wdata_n;
  logic        err_q, err_n, err_set;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  region_t     region;

  c6502_ram #(.AW(RAM_AW)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (bus.cpu_address[RAM_AW-1:0]),
    .wdata (bus.cpu_out),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    we_n        = we_q;
    wdata_n     = wdata_q;
    cpu_in_n    = cpu_in_q;
    ce_n        = 1'b0;
    io_addr_n   = io_addr_q;
    io_wdata_n  = io_wdata_q;
    io_we_n     = 1'b0;
    io_rd_n     = 1'b0;
    ext_req_n   = ext_req_q;
    ext_we_n    = ext_we_q;
    ext_addr_n  = ext_addr_q;
    ext_wdata_n = ext_wdata_q;
    err_set     = 1'b0;
    ram_we      = 1'b0;
    region      = decode_region(bus.cpu_address, IO_BASE);

    case (state)
      S_ADDR: begin
        we_n    = bus.cpu_we;
        wdata_n = bus.cpu_out;
        case (region)
          REG_RAM: begin
            ram_we  = bus.cpu_we;
            state_n = S_RAM;
          end
          REG_IO: begin
            io_addr_n  = bus.cpu_address[7:0];
            io_wdata_n = bus.cpu_out;
            io_we_n    = bus.cpu_we;
            io_rd_n    = bus.cpu_rd & ~bus.cpu_we;
            state_n    = S_IO;
          end
          default: begin
            ext_req_n   = 1'b1;
            ext_we_n    = bus.cpu_we;
            ext_addr_n  = bus.cpu_address;
            ext_wdata_n = bus.cpu_out;
            cnt_n       = 8'd0;
            state_n     = S_EXT;
          end
        endcase
      end
      S_RAM: begin
        cpu_in_n = we_q ? wdata_q : ram_rdata;
        ce_n     = 1'b1;
        state_n  = S_STEP;
      end
      S_IO: begin
        cpu_in_n = we_q ? wdata_q : bus.io_rdata;
        ce_n     = 1'b1;
        state_n  = S_STEP;
      end
      S_EXT: begin
        // An ack on the expiry clock still counts as a normal completion.
        if (bus.ext_ack) begin
          cpu_in_n  = we_q ? wdata_q : bus.ext_rdata;
          ext_req_n = 1'b0;
          ext_we_n  = 1'b0;
          ce_n      = 1'b1;
          state_n   = S_STEP;
        end else if (cnt == TO_LAST) begin
          cpu_in_n  = TIMEOUT_FILL;
          ext_req_n = 1'b0;
          ext_we_n  = 1'b0;
          err_set   = 1'b1;
          ce_n      = 1'b1;
          state_n   = S_STEP;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_STEP:  state_n = S_ADDR;
      default: state_n = S_ADDR;
    endcase

    err_n = err_set | (err_q & ~bus.bus_err_clr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_ADDR;
      cnt         <= 8'd0;
      we_q        <= 1'b0;
      wdata_q     <= 8'h00;
      cpu_in_q    <= 8'h00;
      ce_q        <= 1'b0;
      io_addr_q   <= 8'h00;
      io_wdata_q  <= 8'h00;
      io_we_q     <= 1'b0;
      io_rd_q     <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 16'h0000;
      ext_wdata_q <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      we_q        <= we_n;
      wdata_q     <= wdata_n;
      cpu_in_q    <= cpu_in_n;
      ce_q        <= ce_n;
      io_addr_q   <= io_addr_n;
      io_wdata_q  <= io_wdata_n;
      io_we_q     <= io_we_n;
      io_rd_q     <= io_rd_n;
      ext_req_q   <= ext_req_n;
      ext_we_q    <= ext_we_n;
      ext_addr_q  <= ext_addr_n;
      ext_wdata_q <= ext_wdata_n;
      err_q       <= err_n;
    end
  end

  assign bus.cpu_in    = cpu_in_q;
  assign bus.cpu_ce    = ce_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wdata  = io_wdata_q;
  assign bus.io_we     = io_we_q;
  assign bus.io_rd     = io_rd_q;
  assign bus.ext_req   = ext_req_q;
  assign bus.ext_we    = ext_we_q;
  assign bus.ext_addr  = ext_addr_q;
  assign bus.ext_wdata = ext_wdata_q;
  assign bus.bus_err   = err_q;
  assign dbg_state     = state;

endmodule
